// File: rtl/flash_program_sequencer.sv
// ---------------------------------------------------------------------------
// flash_program_sequencer
//
// Drives a QSPI memory controller to program a multi-page image into NOR
// flash. Optionally checks the JEDEC manufacturer byte (RDID) first. Each
// 64 KiB sector is erased on entry (WREN+SE). Each 256-byte page is then
// written with WREN+PP. Only one controller command is in flight at a time.
//
// Ports
//   CLK_100M, RESET      clock, synchronous active-high reset (shared with
//                        the controller)
//   start                1-cycle job request, only looked at while idle
//   start_addr[23:0]     first page address, low byte forced to zero
//   num_pages[15:0]      number of 256-byte pages in the job
//   page_data[2047:0]    page payload from the image source, byte 0 in MSBs
//   page_valid           payload valid
//   page_ready           page taken on page_valid && page_ready
//   busy                 job in progress (through the done cycle)
//   done                 1-cycle pulse at job end, success or failure
//   error, err_code[2:0] sticky failure flag and reason:
//                        0 none, 1 ID mismatch, 2 range overflow,
//                        3 erase fail, 4 program fail
//   pages_done[15:0]     pages programmed successfully in this job
//   ctrl_trigger         1-cycle command strobe to the controller
//   ctrl_cmd[7:0]        opcode (RDID / WREN / SE / PP)
//   ctrl_addr[23:0]      command address
//   ctrl_data[2047:0]    latched page for PP
//   ctrl_quad            constant QUAD
//   ctrl_busy            controller busy
//   ctrl_error           controller error, valid while ctrl_busy is low
//   ctrl_readout[7:0]    controller read-back byte
// ---------------------------------------------------------------------------
module flash_program_sequencer #(
    parameter int         SECTOR_BITS = 16,
    parameter bit         CHECK_ID    = 1'b1,
    parameter logic [7:0] EXPECTED_ID = 8'h20,
    parameter bit         QUAD        = 1'b0
) (
    input  logic          CLK_100M,
    input  logic          RESET,
    input  logic          start,
    input  logic [23:0]   start_addr,
    input  logic [15:0]   num_pages,
    input  logic [2047:0] page_data,
    input  logic          page_valid,
    output logic          page_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [2:0]    err_code,
    output logic [15:0]   pages_done,
    output logic          ctrl_trigger,
    output logic [7:0]    ctrl_cmd,
    output logic [23:0]   ctrl_addr,
    output logic [2047:0] ctrl_data,
    output logic          ctrl_quad,
    input  logic          ctrl_busy,
    input  logic          ctrl_error,
    input  logic [7:0]    ctrl_readout
);

    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_SE   = 8'hD8;
    localparam logic [7:0] CMD_PP   = 8'h02;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_ID    = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_ERASE = 3'd3;
    localparam logic [2:0] ERR_PROG  = 3'd4;

    localparam logic [23:0] SECT_MASK = (24'h1 << SECTOR_BITS) - 24'h1;

    typedef enum logic [2:0] {
        S_IDLE, S_PAGE_CHK, S_FETCH, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_END
    } state_t;

    // Which command the shared ISSUE/WAIT_HI/WAIT_LO sub-sequence is running;
    // decides where WAIT_LO branches to.
    typedef enum logic [2:0] {
        OP_RDID, OP_WREN_SE, OP_SE, OP_WREN_PP, OP_PP
    } op_t;

    state_t state, state_nxt;
    op_t    op, op_nxt;

    logic [23:0]   cur_addr, cur_addr_nxt;
    logic [15:0]   npages, npages_nxt;
    logic          first_pg, first_pg_nxt;
    logic          busy_nxt, done_nxt, error_nxt, page_ready_nxt, trigger_nxt;
    logic [2:0]    err_code_nxt;
    logic [15:0]   pages_done_nxt, pages_inc;
    logic [7:0]    cmd_nxt;
    logic [23:0]   addr_nxt;
    logic [2047:0] data_nxt;

    logic [24:0]   job_end;
    logic          range_ovf;
    logic          need_erase;
    logic          unused_ok;

    // End of the job's address range, one bit wider so a wrap past 16 MiB is
    // visible. Ending exactly at 2^24 is still legal.
    assign job_end    = {1'b0, start_addr[23:8], 8'h00} + {1'b0, num_pages, 8'h00};
    assign range_ovf  = job_end > 25'h100_0000;
    assign need_erase = first_pg || ((cur_addr & SECT_MASK) == 24'h0);
    assign pages_inc  = pages_done + 16'd1;
    assign unused_ok  = ^start_addr[7:0];

    always_ff @(posedge CLK_100M) begin
        if (RESET) begin
            state        <= S_IDLE;
            op           <= OP_RDID;
            cur_addr     <= '0;
            npages       <= '0;
            first_pg     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            pages_done   <= '0;
            page_ready   <= 1'b0;
            ctrl_trigger <= 1'b0;
            ctrl_cmd     <= '0;
            ctrl_addr    <= '0;
            ctrl_data    <= '0;
            ctrl_quad    <= QUAD;
        end else begin
            state        <= state_nxt;
            op           <= op_nxt;
            cur_addr     <= cur_addr_nxt;
            npages       <= npages_nxt;
            first_pg     <= first_pg_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
            err_code     <= err_code_nxt;
            pages_done   <= pages_done_nxt;
            page_ready   <= page_ready_nxt;
            ctrl_trigger <= trigger_nxt;
            ctrl_cmd     <= cmd_nxt;
            ctrl_addr    <= addr_nxt;
            ctrl_data    <= data_nxt;
            ctrl_quad    <= QUAD;
        end
    end

    always_comb begin
        state_nxt      = state;
        op_nxt         = op;
        cur_addr_nxt   = cur_addr;
        npages_nxt     = npages;
        first_pg_nxt   = first_pg;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        error_nxt      = error;
        err_code_nxt   = err_code;
        pages_done_nxt = pages_done;
        page_ready_nxt = page_ready;
        trigger_nxt    = 1'b0;
        cmd_nxt        = ctrl_cmd;
        addr_nxt       = ctrl_addr;
        data_nxt       = ctrl_data;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    busy_nxt       = 1'b1;
                    error_nxt      = 1'b0;
                    err_code_nxt   = ERR_NONE;
                    pages_done_nxt = '0;
                    cur_addr_nxt   = {start_addr[23:8], 8'h00};
                    npages_nxt     = num_pages;
                    first_pg_nxt   = 1'b1;
                    if (range_ovf) begin
                        error_nxt    = 1'b1;
                        err_code_nxt = ERR_RANGE;
                        done_nxt     = 1'b1;
                        state_nxt    = S_END;
                    end else if (num_pages == 16'd0) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_END;
                    end else if (CHECK_ID) begin
                        op_nxt    = OP_RDID;
                        cmd_nxt   = CMD_RDID;
                        addr_nxt  = '0;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_PAGE_CHK;
                    end
                end
            end

            S_PAGE_CHK: begin
                if (need_erase) begin
                    op_nxt    = OP_WREN_SE;
                    cmd_nxt   = CMD_WREN;
                    addr_nxt  = '0;
                    state_nxt = S_ISSUE;
                end else begin
                    page_ready_nxt = 1'b1;
                    state_nxt      = S_FETCH;
                end
            end

            S_FETCH: begin
                if (page_valid && page_ready) begin
                    data_nxt       = page_data;
                    page_ready_nxt = 1'b0;
                    op_nxt         = OP_WREN_PP;
                    cmd_nxt        = CMD_WREN;
                    addr_nxt       = '0;
                    state_nxt      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!ctrl_busy) begin
                    trigger_nxt = 1'b1;
                    state_nxt   = S_WAIT_HI;
                end
            end

            S_WAIT_HI: begin
                if (ctrl_busy) state_nxt = S_WAIT_LO;
            end

            S_WAIT_LO: begin
                if (!ctrl_busy) begin
                    case (op)
                        OP_RDID: begin
                            if (ctrl_readout != EXPECTED_ID) begin
                                error_nxt    = 1'b1;
                                err_code_nxt = ERR_ID;
                                done_nxt     = 1'b1;
                                state_nxt    = S_END;
                            end else begin
                                state_nxt = S_PAGE_CHK;
                            end
                        end
                        // A failed WREN means the following SE/PP cannot
                        // succeed, so it is reported as that operation's failure.
                        OP_WREN_SE: begin
                            if (ctrl_error) begin
                                error_nxt    = 1'b1;
                                err_code_nxt = ERR_ERASE;
                                done_nxt     = 1'b1;
                                state_nxt    = S_END;
                            end else begin
                                op_nxt    = OP_SE;
                                cmd_nxt   = CMD_SE;
                                addr_nxt  = cur_addr & ~SECT_MASK;
                                state_nxt = S_ISSUE;
                            end
                        end
                        OP_SE: begin
                            if (ctrl_error) begin
                                error_nxt    = 1'b1;
                                err_code_nxt = ERR_ERASE;
                                done_nxt     = 1'b1;
                                state_nxt    = S_END;
                            end else begin
                                first_pg_nxt   = 1'b0;
                                page_ready_nxt = 1'b1;
                                state_nxt      = S_FETCH;
                            end
                        end
                        OP_WREN_PP: begin
                            if (ctrl_error) begin
                                error_nxt    = 1'b1;
                                err_code_nxt = ERR_PROG;
                                done_nxt     = 1'b1;
                                state_nxt    = S_END;
                            end else begin
                                op_nxt    = OP_PP;
                                cmd_nxt   = CMD_PP;
                                addr_nxt  = cur_addr;
                                state_nxt = S_ISSUE;
                            end
                        end
                        OP_PP: begin
                            if (ctrl_error) begin
                                error_nxt    = 1'b1;
                                err_code_nxt = ERR_PROG;
                                done_nxt     = 1'b1;
                                state_nxt    = S_END;
                            end else begin
                                pages_done_nxt = pages_inc;
                                cur_addr_nxt   = cur_addr + 24'd256;
                                if (pages_inc == npages) begin
                                    done_nxt  = 1'b1;
                                    state_nxt = S_END;
                                end else begin
                                    state_nxt = S_PAGE_CHK;
                                end
                            end
                        end
                        default: begin
                            state_nxt = S_IDLE;
                        end
                    endcase
                end
            end

            // done is high for this one cycle; busy drops on the way out.
            S_END: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_program_sequencer.sv
module tb_flash_program_sequencer;

    logic          CLK_100M = 1'b0;
    logic          RESET;
    logic          start;
    logic [23:0]   start_addr;
    logic [15:0]   num_pages;
    logic [2047:0] page_data;
    logic          page_valid;
    logic          page_ready;
    logic          busy, done, error;
    logic [2:0]    err_code;
    logic [15:0]   pages_done;
    logic          ctrl_trigger;
    logic [7:0]    ctrl_cmd;
    logic [23:0]   ctrl_addr;
    logic [2047:0] ctrl_data;
    logic          ctrl_quad;
    logic          ctrl_busy, ctrl_error;
    logic [7:0]    ctrl_readout;

    always #5 CLK_100M = ~CLK_100M;

    flash_program_sequencer dut (
        .CLK_100M(CLK_100M), .RESET(RESET), .start(start), .start_addr(start_addr),
        .num_pages(num_pages), .page_data(page_data), .page_valid(page_valid),
        .page_ready(page_ready), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .pages_done(pages_done), .ctrl_trigger(ctrl_trigger),
        .ctrl_cmd(ctrl_cmd), .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data),
        .ctrl_quad(ctrl_quad), .ctrl_busy(ctrl_busy), .ctrl_error(ctrl_error),
        .ctrl_readout(ctrl_readout)
    );

    // ---------------- controller model ----------------
    logic [7:0]  rd_val;
    int          pp_err_idx;
    int          page_delay;

    logic        cbusy, cerr, hs_viol;
    int          ccnt, nlog, pp_cnt;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [31:0] log_q [0:15];
    logic        pp_ok [0:15];

    assign ctrl_busy    = cbusy;
    assign ctrl_error   = cerr;
    assign ctrl_readout = rd_val;

    always @(posedge CLK_100M) begin
        if (RESET) begin
            cbusy <= 1'b0; cerr <= 1'b0; ccnt <= 0; nlog <= 0; pp_cnt <= 0; hs_viol <= 1'b0;
            m_cmd <= '0; m_addr <= '0;
        end else if (ctrl_trigger) begin
            if (cbusy) hs_viol <= 1'b1;
            cbusy  <= 1'b1;
            ccnt   <= 3;
            m_cmd  <= ctrl_cmd;
            m_addr <= ctrl_addr;
            if (nlog < 16) log_q[nlog] <= {ctrl_cmd, ctrl_addr};
            nlog <= nlog + 1;
            cerr <= 1'b0;
            if (ctrl_cmd == 8'h02) begin
                if (pp_cnt < 16) pp_ok[pp_cnt] <= (ctrl_data == {256{8'hA0 + pp_cnt[7:0]}});
                cerr   <= (pp_cnt == pp_err_idx);
                pp_cnt <= pp_cnt + 1;
            end
        end else if (ccnt != 0) begin
            if (ctrl_cmd != m_cmd || ctrl_addr != m_addr) hs_viol <= 1'b1;
            ccnt <= ccnt - 1;
            if (ccnt == 1) cbusy <= 1'b0;
        end
    end

    // ---------------- page source: page k carries byte 0xA0+k ----------------
    int   pg_idx, dly;
    logic pv;
    assign page_valid = pv;
    assign page_data  = {256{8'hA0 + pg_idx[7:0]}};

    always @(posedge CLK_100M) begin
        if (RESET) begin
            pv <= 1'b0; dly <= 0; pg_idx <= 0;
        end else if (pv && page_ready) begin
            pv <= 1'b0; dly <= 0; pg_idx <= pg_idx + 1;
        end else if (page_ready && !pv) begin
            if (dly >= page_delay) pv <= 1'b1;
            else dly <= dly + 1;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    localparam logic [31:0] E_RD = {8'h9F, 24'h0};
    localparam logic [31:0] E_WR = {8'h06, 24'h0};
    function automatic logic [31:0] e_se(input logic [23:0] a); return {8'hD8, a}; endfunction
    function automatic logic [31:0] e_pp(input logic [23:0] a); return {8'h02, a}; endfunction

    typedef struct {
        logic [23:0]      addr;
        logic [15:0]      n;
        logic [7:0]       rd;
        int               pperr;
        int               dly;
        int               restart;
        logic [2:0]       code;
        logic [15:0]      pd;
        int               fetched;
        logic             quick;
        int               ncmd;
        logic [9:0][31:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [23:0] a, input logic [15:0] n, input logic [7:0] rd,
                                input int pperr, input int dl, input int rs, input logic [2:0] code,
                                input logic [15:0] pd, input int fetched, input logic quick);
        vec_t v;
        v.addr = a; v.n = n; v.rd = rd; v.pperr = pperr; v.dly = dl; v.restart = rs;
        v.code = code; v.pd = pd; v.fetched = fetched; v.quick = quick; v.ncmd = 0; v.exp = '0;
        return v;
    endfunction

    task automatic add(input int i, input logic [31:0] e);
        vecs[i].exp[vecs[i].ncmd] = e;
        vecs[i].ncmd++;
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK_100M);
        RESET = 1'b1; start = 1'b0;
        @(negedge CLK_100M);
        chk({tag, ":rst_flags"}, {busy, done, error, err_code, page_ready, ctrl_trigger, ctrl_quad}, 0);
        chk({tag, ":rst_pages_done"}, pages_done, 0);
        chk({tag, ":rst_cmd_addr"}, {ctrl_cmd, ctrl_addr}, 0);
        chk({tag, ":rst_data"}, |ctrl_data, 0);
        RESET = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        int    cyc;
        int    npp;
        t = $sformatf("v%0d", idx);
        rd_val = v.rd; pp_err_idx = v.pperr; page_delay = v.dly;
        do_reset(t);
        @(negedge CLK_100M);
        start = 1'b1; start_addr = v.addr; num_pages = v.n;
        @(negedge CLK_100M);
        start = 1'b0;
        chk({t, ":busy_after_start"}, busy, 1);
        chk({t, ":done_latency"}, done, v.quick);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            if (v.restart != 0 && cyc == v.restart) begin
                start = 1'b1; start_addr = 24'hFFFF00; num_pages = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK_100M);
            cyc++;
        end
        start = 1'b0;
        chk({t, ":done_seen"}, done, 1);
        chk({t, ":busy_on_done"}, busy, 1);
        chk({t, ":error"}, error, (v.code != 3'd0));
        chk({t, ":err_code"}, err_code, v.code);
        chk({t, ":pages_done"}, pages_done, v.pd);
        @(negedge CLK_100M);
        chk({t, ":done_pulse_end"}, {done, busy}, 0);
        chk({t, ":error_sticky"}, {error, err_code}, {(v.code != 3'd0), v.code});
        chk({t, ":ncmds"}, nlog, v.ncmd);
        npp = 0;
        for (int i = 0; i < v.ncmd && i < nlog; i++) begin
            chk($sformatf("%s:cmd%0d", t, i), log_q[i], v.exp[i]);
            if (v.exp[i][31:24] == 8'h02) begin
                chk($sformatf("%s:pp_data%0d", t, npp), pp_ok[npp], 1);
                npp++;
            end
        end
        chk({t, ":pages_fetched"}, pg_idx, v.fetched);
        chk({t, ":handshake"}, hs_viol, 0);
    endtask

    initial begin
        int   cyc;
        logic seen;
        RESET = 1'b1; start = 1'b0; start_addr = '0; num_pages = '0;
        rd_val = 8'h20; pp_err_idx = -1; page_delay = 0;

        vecs[0] = mk(24'h010000, 1, 8'h20, -1, 0, 0, 3'd0, 1, 1, 1'b0);
        add(0, E_RD); add(0, E_WR); add(0, e_se(24'h010000)); add(0, E_WR); add(0, e_pp(24'h010000));
        vecs[1] = mk(24'h00FF00, 2, 8'h20, -1, 0, 0, 3'd0, 2, 2, 1'b0);
        add(1, E_RD); add(1, E_WR); add(1, e_se(24'h000000)); add(1, E_WR); add(1, e_pp(24'h00FF00));
        add(1, E_WR); add(1, e_se(24'h010000)); add(1, E_WR); add(1, e_pp(24'h010000));
        vecs[2] = mk(24'h020000, 1, 8'hC2, -1, 0, 0, 3'd1, 0, 0, 1'b0);
        add(2, E_RD);
        vecs[3] = mk(24'h030000, 3, 8'h20, 1, 0, 0, 3'd4, 1, 2, 1'b0);
        add(3, E_RD); add(3, E_WR); add(3, e_se(24'h030000)); add(3, E_WR); add(3, e_pp(24'h030000));
        add(3, E_WR); add(3, e_pp(24'h030100));
        vecs[4] = mk(24'hFFFF00, 2, 8'h20, -1, 0, 0, 3'd2, 0, 0, 1'b1);
        vecs[5] = mk(24'h040000, 0, 8'h20, -1, 0, 0, 3'd0, 0, 0, 1'b1);
        vecs[6] = mk(24'hFFFF00, 1, 8'h20, -1, 0, 0, 3'd0, 1, 1, 1'b0);
        add(6, E_RD); add(6, E_WR); add(6, e_se(24'hFF0000)); add(6, E_WR); add(6, e_pp(24'hFFFF00));
        vecs[7] = mk(24'h050080, 1, 8'h20, -1, 20, 0, 3'd0, 1, 1, 1'b0);
        add(7, E_RD); add(7, E_WR); add(7, e_se(24'h050000)); add(7, E_WR); add(7, e_pp(24'h050000));
        vecs[8] = mk(24'h07FF00, 2, 8'h20, -1, 0, 5, 3'd0, 2, 2, 1'b0);
        add(8, E_RD); add(8, E_WR); add(8, e_se(24'h070000)); add(8, E_WR); add(8, e_pp(24'h07FF00));
        add(8, E_WR); add(8, e_se(24'h080000)); add(8, E_WR); add(8, e_pp(24'h080000));
        vecs[9] = mk(24'h090000, 2, 8'h20, 0, 0, 0, 3'd4, 0, 1, 1'b0);
        add(9, E_RD); add(9, E_WR); add(9, e_se(24'h090000)); add(9, E_WR); add(9, e_pp(24'h090000));

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Stalled page source, then RESET while the PP is in flight.
        rd_val = 8'h20; pp_err_idx = -1; page_delay = 20;
        do_reset("abort");
        @(negedge CLK_100M);
        start = 1'b1; start_addr = 24'h060000; num_pages = 16'd1;
        @(negedge CLK_100M);
        start = 1'b0;
        cyc = 0;
        while (page_ready !== 1'b1 && cyc < 500) begin @(negedge CLK_100M); cyc++; end
        chk("abort:ready_seen", page_ready, 1);
        repeat (10) @(negedge CLK_100M);
        chk("abort:no_pp_while_stalled", nlog, 3);
        chk("abort:ready_held", page_ready, 1);
        cyc = 0;
        while (!(nlog == 5 && ctrl_busy) && cyc < 500) begin @(negedge CLK_100M); cyc++; end
        chk("abort:pp_in_flight", {nlog == 5, ctrl_busy}, 2'b11);
        chk("abort:pp_addr", log_q[4], e_pp(24'h060000));
        RESET = 1'b1;
        @(negedge CLK_100M);
        chk("abort:flags_zero", {busy, done, error, err_code, page_ready, ctrl_trigger, ctrl_quad}, 0);
        chk("abort:regs_zero", {pages_done, ctrl_cmd, ctrl_addr}, 0);
        chk("abort:data_zero", |ctrl_data, 0);
        RESET = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK_100M);
            if (done || busy) seen = 1'b1;
        end
        chk("abort:no_done_after", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
